// File: rtl/mem_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl_pkg
//  Description : Shared constants and helpers for the MEM-stage load/store
//                initiator: RISC-V width codes, FSM encodings, size decode.
//  Revision    : 1.0 - initial release
// ============================================================================
package mem_access_ctrl_pkg;

   // RISC-V load/store width codes (funct3)
   localparam logic [2:0] F3_B  = 3'b000;   // LB / SB
   localparam logic [2:0] F3_H  = 3'b001;   // LH / SH
   localparam logic [2:0] F3_W  = 3'b010;   // LW / SW
   localparam logic [2:0] F3_BU = 3'b100;   // LBU
   localparam logic [2:0] F3_HU = 3'b101;   // LHU

   // FSM state encodings
   localparam int         STATE_W = 2;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ACC1 = 2'd1;
   localparam logic [1:0] ST_ACC2 = 2'd2;
   localparam logic [1:0] ST_DONE = 2'd3;

   // Access size in bytes from funct3[1:0]; only legal codes reach the datapath
   function automatic logic [3:0] size_of(input logic [1:0] f);
      case (f)
         2'b00:   size_of = 4'd1;
         2'b01:   size_of = 4'd2;
         default: size_of = 4'd4;
      endcase
   endfunction

   // Unsigned variants exist for loads only; everything else is undefined
   function automatic logic f3_illegal(input logic [2:0] f3, input logic we);
      case (f3)
         F3_B, F3_H, F3_W: f3_illegal = 1'b0;
         F3_BU, F3_HU:     f3_illegal = we;
         default:          f3_illegal = 1'b1;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_ctrl_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_align
//  Description : Combinational byte-lane alignment. Builds the 8-lane mask
//                and lane-positioned store data spanning two words, and
//                extracts/extends load data from the two captured words.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
   import mem_access_ctrl_pkg::*;
(
   input  logic [1:0]  off_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] wdata_i,
   input  logic [31:0] buf0_i,
   input  logic [31:0] buf1_i,
   output logic [7:0]  mask_o,
   output logic [63:0] lanes_o,
   output logic [31:0] load_o
);

   logic [7:0]  w_base;
   logic [4:0]  w_shamt;
   logic [63:0] w_shifted;

   assign w_shamt = {off_i, 3'b000};

   // Store side: size mask and data shifted onto their byte lanes
   always_comb begin
      case (funct3_i[1:0])
         2'b00:   w_base = 8'h01;
         2'b01:   w_base = 8'h03;
         default: w_base = 8'h0F;
      endcase
      mask_o  = w_base << off_i;
      lanes_o = {32'h0, wdata_i} << w_shamt;
   end

   // Load side: bring the addressed bytes down to bit 0, truncate and extend
   always_comb begin
      w_shifted = {buf1_i, buf0_i} >> w_shamt;
      case (funct3_i)
         F3_B:    load_o = {{24{w_shifted[7]}},  w_shifted[7:0]};
         F3_H:    load_o = {{16{w_shifted[15]}}, w_shifted[15:0]};
         F3_W:    load_o = w_shifted[31:0];
         F3_BU:   load_o = {24'h0, w_shifted[7:0]};
         F3_HU:   load_o = {16'h0, w_shifted[15:0]};
         default: load_o = 32'h0;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/mem_access_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mem_access_ctrl
//  Description : MEM-stage load/store initiator. Accepts one request at a
//                time, drives the data RAM port, splits word-crossing
//                accesses into two word accesses and returns a one-cycle
//                response with the extended load result.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_access_ctrl
   import mem_access_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [31:0]       req_wdata,
   output logic              resp_valid,
   output logic [31:0]       resp_rdata,
   output logic              resp_err,
   output logic              mem_ce,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [3:0]        mem_sel,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata
);

   logic [STATE_W-1:0] state_q, state_d;
   logic               we_q;
   logic [2:0]         funct3_q;
   logic [ADDR_W-1:0]  addr_q;
   logic [31:0]        wdata_q;
   logic [31:0]        buf0_q;
   logic [31:0]        buf1_q;
   logic               err_q;

   logic [7:0]         w_mask;
   logic [63:0]        w_lanes;
   logic [31:0]        w_load;
   logic               w_split;
   logic [ADDR_W-1:0]  w_word_addr;

   // A split is needed when the access runs past the last byte of its word
   assign w_split     = (({2'b00, addr_q[1:0]} + size_of(funct3_q[1:0])) > 4'd4);
   assign w_word_addr = {addr_q[ADDR_W-1:2], 2'b00};

   lsu_align u_align (
      .off_i    (addr_q[1:0]),
      .funct3_i (funct3_q),
      .wdata_i  (wdata_q),
      .buf0_i   (buf0_q),
      .buf1_i   (buf1_q),
      .mask_o   (w_mask),
      .lanes_o  (w_lanes),
      .load_o   (w_load)
   );

   // State register
   always_ff @(posedge clk) begin
      if (!rst) state_q <= ST_IDLE;
      else      state_q <= state_d;
   end

   // Request latch and load capture buffers
   always_ff @(posedge clk) begin
      if (!rst) begin
         we_q     <= 1'b0;
         funct3_q <= 3'b000;
         addr_q   <= '0;
         wdata_q  <= 32'h0;
         buf0_q   <= 32'h0;
         buf1_q   <= 32'h0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (req_valid) begin
                  we_q     <= req_we;
                  funct3_q <= req_funct3;
                  addr_q   <= req_addr;
                  wdata_q  <= req_wdata;
                  err_q    <= f3_illegal(req_funct3, req_we);
                  buf0_q   <= 32'h0;
                  buf1_q   <= 32'h0;
               end
            end
            ST_ACC1: if (!we_q) buf0_q <= mem_rdata;
            ST_ACC2: if (!we_q) buf1_q <= mem_rdata;
            default: ;
         endcase
      end
   end

   // Next-state logic; illegal requests skip the RAM entirely
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               if (f3_illegal(req_funct3, req_we)) state_d = ST_DONE;
               else                                state_d = ST_ACC1;
            end
         end
         ST_ACC1: state_d = w_split ? ST_ACC2 : ST_DONE;
         ST_ACC2: state_d = ST_DONE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Output decode; the RAM port is quiet outside the two access states
   always_comb begin
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_err   = 1'b0;
      resp_rdata = 32'h0;
      mem_ce     = 1'b0;
      mem_we     = 1'b0;
      mem_addr   = '0;
      mem_sel    = 4'h0;
      mem_wdata  = 32'h0;
      case (state_q)
         ST_IDLE: req_ready = 1'b1;
         ST_ACC1: begin
            mem_ce    = 1'b1;
            mem_we    = we_q;
            mem_addr  = w_word_addr;
            mem_sel   = w_mask[3:0];
            mem_wdata = w_lanes[31:0];
         end
         ST_ACC2: begin
            mem_ce    = 1'b1;
            mem_we    = we_q;
            mem_addr  = w_word_addr + ADDR_W'(4);   // wraps at the top of memory
            mem_sel   = w_mask[7:4];
            mem_wdata = w_lanes[63:32];
         end
         default: begin
            resp_valid = 1'b1;
            resp_err   = err_q;
            resp_rdata = (we_q || err_q) ? 32'h0 : w_load;
         end
      endcase
   end

endmodule
`default_nettype wire
